dmem_mmio_responder: RTL and testbench
======================================

# dmem_mmio_responder

Responder end of the processor's data-memory port: it accepts `address_dmem`/`data`/`wren` from the pipeline's memory stage and returns `q_dmem` for the writeback latch to capture. Low addresses map to a word-addressed RAM. A small memory-mapped I/O window provides:
- a byte-transmit FIFO that drains over a valid/ready stream;
- a status register;
- a free-running cycle counter.

It sits in the wrapper beside the instruction memory and register file.

## Interface
Parameters:
- `RAM_AW`, 12: RAM address width in words (4096 × 32 b).
- `FIFO_AW`, 3: transmit FIFO depth = 2^FIFO_AW = 8 entries.
- `MMIO_TAG`, 16'hFFFF: value of `address_dmem[31:16]` that selects the MMIO window.

Ports:
- `clock`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `address_dmem`, in, 32: word address from the memory stage.
- `data`, in, 32: write data.
- `wren`, in, 1: write enable.
- `q_dmem`, out, 32: read data, registered.
- `tx_data`, out, 8: FIFO head byte.
- `tx_valid`, out, 1: FIFO non-empty.
- `tx_ready`, in, 1: sink accepts `tx_data` this cycle.

## Operation
- **Decode.** MMIO when `address_dmem[31:16]==MMIO_TAG`; otherwise RAM at index `address_dmem[RAM_AW-1:0]`. Upper bits are ignored, so the RAM aliases.
- **RAM.**
  - Write on the rising edge when `wren` is high.
  - Read is synchronous: `q_dmem` ← RAM[addr] on the rising edge.
  - Read and write to the same address in one cycle returns the old data (read-first).
  - Contents are not reset.
- **MMIO offsets** (`address_dmem[1:0]`; bits [15:2] are ignored):
  - **0 TXDATA.**
    - Write pushes `data[7:0]`.
    - A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
    - Otherwise the byte is dropped and sticky `ovf` is set.
    - Reads return 0.
  - **1 STATUS** (read): `{23'b0, ovf, 2'b0, full, empty, count[3:0]}`, where `count` is 0..8.
    - A write of any value clears `ovf`.
    - If a TXDATA overflow and a STATUS clear occur in the same cycle, set wins. (They cannot coincide on a single port; this rule only covers a future second port.)
  - **2 CYCLE**: 32-bit counter, +1 every cycle, wraps from 0xFFFFFFFF to 0.
    - A write loads `data`; the counter reads that value on the next cycle and increments from there.
    - Reads return the pre-edge value.
  - **3 ID** (read): constant 32'h0350_0001. Writes are ignored.
  - MMIO writes never touch the RAM.
- **FIFO drain.**
  - `tx_valid = ~empty`; `tx_data` = head entry. Both come straight from FIFO state.
  - Pop when `tx_valid && tx_ready`.
  - Head is stable while `tx_valid && !tx_ready`.
  - Push to an empty FIFO: `tx_valid` rises the next cycle; there is no same-cycle bypass.
- **Read-of-write.** An MMIO read samples state before the edge. STATUS read in the cycle of a push shows the old count.

## Timing
- **Read latency:** 1 rising edge.
  - The address is presented by the pipeline on the falling edge.
  - `q_dmem` is valid after the next rising edge.
  - The processor's writeback latch captures it on the following falling edge.
- **Write:** takes effect at the rising edge of the cycle in which `wren` is high.
- **Reset** (asynchronous, takes effect immediately):
  - `q_dmem`=0, FIFO empty (`tx_valid`=0, `tx_data`=0), `count`=0, `ovf`=0, cycle counter=0.
  - Reset mid-drain discards all queued bytes.
  - RAM is untouched.
- **After reset release:** the cycle counter reads 0 at the first rising edge, then 1, 2, …
- **Full boundary:** `count` saturates at 8. Simultaneous push and pop at `count`=8 keeps `count` at 8 with no `ovf`. Pointers wrap modulo 8.
- **Empty boundary:** simultaneous push and pop cannot occur at `count`=0 (no pop when empty). Push alone moves `count` 0→1.

## Structure
- Package `dmem_map_pkg`: `MMIO_TAG`, offset constants `OFF_TXDATA=0`, `OFF_STATUS=1`, `OFF_CYCLE=2`, `OFF_ID=3`, the `ID_VALUE` constant, and STATUS bit-position constants.
- Sub-module `tx_fifo` (parameter `FIFO_AW`, width 8):
  - Ports: push/pop/din/dout/count/full/empty.
  - Pointer + count implementation with asynchronous reset.
- The top level holds the address decode, RAM array, `q_dmem` register, `ovf` and the cycle counter.

## Test plan
- **RAM:** write 32'hDEADBEEF to addr 5, read addr 5 next cycle → `q_dmem`=32'hDEADBEEF one edge later. Read addr 5+4096 → same value (alias).
- **Cycle counter:** release reset, read CYCLE at edges 3 and 10 → returns 2 and 9. Write 32'hFFFFFFFE, read two cycles later → 0 (wrap).
- **FIFO fill/overflow:** hold `tx_ready`=0, push bytes 0x41..0x49 (9 pushes) → STATUS = 32'h0000_0128 (`ovf`=1, `full`=1, `count`=8). Drain shows 0x41..0x48 in order; 0x49 is lost.
- **Full push+pop:** with `count`=8 and `tx_ready`=1, push 0x5A → `count` stays 8, `ovf` unchanged, 0x5A emerges last.
- **ovf clear / ID / backpressure:** write STATUS → `ovf`=0. Read ID → 32'h0350_0001. Toggle `tx_ready` every other cycle → `tx_data` is held stable while not ready, with no duplicate or lost bytes.
- **Reset mid-drain:** assert `reset` asynchronously with 5 bytes queued → `tx_valid` drops immediately; after release STATUS=32'h0000_0010 (empty); RAM data from the first test is still readable.

Source files
------------

// File: rtl/dmem_mmio_responder_pkg.sv
// Address map shared by the data-memory responder: MMIO window tag,
// register offsets, the ID constant and the STATUS bit layout.
package dmem_map_pkg;

  localparam logic [15:0] MMIO_TAG = 16'hFFFF;

  typedef enum logic [1:0] {
    OFF_TXDATA = 2'd0,
    OFF_STATUS = 2'd1,
    OFF_CYCLE  = 2'd2,
    OFF_ID     = 2'd3
  } mmio_off_e;

  localparam logic [31:0] ID_VALUE = 32'h0350_0001;

  localparam int ST_COUNT_LSB = 0;
  localparam int ST_EMPTY_BIT = 4;
  localparam int ST_FULL_BIT  = 5;
  localparam int ST_OVF_BIT   = 8;

  // Assemble the STATUS word so the bit layout lives in one place
  function automatic logic [31:0] pack_status(input logic ovf, input logic full,
                                              input logic empty, input logic [3:0] count);
    logic [31:0] s;
    s = '0;
    s[ST_COUNT_LSB +: 4] = count;
    s[ST_EMPTY_BIT]      = empty;
    s[ST_FULL_BIT]       = full;
    s[ST_OVF_BIT]        = ovf;
    return s;
  endfunction

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// Data-memory port between the pipeline memory stage and the responder,
// plus the byte stream that drains the transmit FIFO.
interface dmem_mmio_responder_if;
  import dmem_map_pkg::*;

  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output address_dmem, data, wren, tx_ready,
    input  q_dmem, tx_data, tx_valid
  );

  modport slave (
    input  address_dmem, data, wren, tx_ready,
    output q_dmem, tx_data, tx_valid
  );

endinterface

// File: rtl/dmem_mmio_responder_tx_fifo.sv
// Byte transmit FIFO: pointer + occupancy counter, asynchronous reset.
// A push into a full FIFO is taken only when a pop frees a slot that edge.
module tx_fifo
  import dmem_map_pkg::*;
#(
  parameter int FIFO_AW = 3,
  parameter int WIDTH   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout,
  output logic [FIFO_AW:0]   count,
  output logic               full,
  output logic               empty
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == (FIFO_AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when empty so the stream idles at 0 after reset
  assign dout = empty ? '0 : mem[rd_ptr];

  // Storage is not reset; only pointers and count define validity
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM in the low space, MMIO window (TX FIFO,
// STATUS, cycle counter, ID) when the upper address half matches the tag.
// All reads are registered into q_dmem one rising edge after the address.
module dmem_mmio_responder #(
  parameter int          RAM_AW   = 12,
  parameter int          FIFO_AW  = 3,
  parameter logic [15:0] MMIO_TAG = dmem_map_pkg::MMIO_TAG
) (
  input logic                  clock,
  input logic                  reset,
  dmem_mmio_responder_if.slave bus
);
  import dmem_map_pkg::*;

  localparam int RAM_WORDS = 1 << RAM_AW;

  logic [31:0]       ram [RAM_WORDS];
  logic              is_mmio;
  mmio_off_e         offset;
  logic [RAM_AW-1:0] ram_idx;
  logic              mmio_wr;
  logic              push;
  logic              pop;
  logic              overflow;
  logic              status_clr;
  logic              cycle_wr;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_AW:0]  fifo_count;
  logic              ovf;
  logic [31:0]       cycle_cnt;
  logic [31:0]       mmio_rdata;
  logic              unused_addr;

  // Bits between the RAM index and the tag, and [15:2] in the window, alias
  assign unused_addr = ^bus.address_dmem;

  assign is_mmio    = (bus.address_dmem[31:16] == MMIO_TAG);
  assign offset     = mmio_off_e'(bus.address_dmem[1:0]);
  assign ram_idx    = bus.address_dmem[RAM_AW-1:0];
  assign mmio_wr    = bus.wren && is_mmio;
  assign push       = mmio_wr && (offset == OFF_TXDATA);
  assign status_clr = mmio_wr && (offset == OFF_STATUS);
  assign cycle_wr   = mmio_wr && (offset == OFF_CYCLE);
  assign pop        = !fifo_empty && bus.tx_ready;
  assign overflow   = push && fifo_full && !pop;
  assign bus.tx_valid = !fifo_empty;

  tx_fifo #(
    .FIFO_AW (FIFO_AW),
    .WIDTH   (8)
  ) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.data[7:0]),
    .dout  (bus.tx_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // MMIO read mux samples register state before the edge
  always_comb begin
    mmio_rdata = '0;
    case (offset)
      OFF_STATUS: mmio_rdata = pack_status(ovf, fifo_full, fifo_empty, 4'(fifo_count));
      OFF_CYCLE:  mmio_rdata = cycle_cnt;
      OFF_ID:     mmio_rdata = ID_VALUE;
      default:    mmio_rdata = '0;
    endcase
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clock) begin
    if (bus.wren && !is_mmio) ram[ram_idx] <= bus.data;
  end

  // Registered read data; RAM reads are read-first against a same-edge write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) bus.q_dmem <= '0;
    else       bus.q_dmem <= is_mmio ? mmio_rdata : ram[ram_idx];
  end

  // Sticky overflow flag; a set in the same cycle as a clear wins
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           ovf <= 1'b0;
    else if (overflow)   ovf <= 1'b1;
    else if (status_clr) ovf <= 1'b0;
  end

  // Free-running cycle counter, loadable from the bus
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         cycle_cnt <= '0;
    else if (cycle_wr) cycle_cnt <= bus.data;
    else               cycle_cnt <= cycle_cnt + 32'd1;
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder. Inputs change on the falling
// edge, outputs are sampled on the following falling edge. A behavioural
// model (RAM array, byte queue, overflow flag, cycle value) predicts q_dmem
// and the transmit stream for every cycle.
module tb_dmem_mmio_responder;

  logic clock;
  logic reset;
  int   n_compared;
  int   n_mismatched;

  dmem_mmio_responder_if bus();

  dmem_mmio_responder #(
    .RAM_AW   (12),
    .FIFO_AW  (3),
    .MMIO_TAG (16'hFFFF)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] ram_m [4096];
  bit          ram_known [4096];
  logic [7:0]  tx_q [$];
  logic        ovf_m;
  logic [31:0] cyc_m;
  logic [31:0] last_q;
  logic [7:0]  exp_drain [8] = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h5A};

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mmio_addr(input logic [1:0] off);
    return {16'hFFFF, 14'($urandom), off};
  endfunction

  function automatic logic [31:0] ram_addr(input int idx);
    logic [15:0] hi;
    hi = 16'($urandom);
    if (hi == 16'hFFFF) hi = 16'h0000;
    return {hi, 4'($urandom), 12'(idx)};
  endfunction

  function automatic logic [31:0] status_word();
    int n;
    n = tx_q.size();
    return {23'b0, ovf_m, 2'b0, (n == 8), (n == 0), 4'(n)};
  endfunction

  function automatic void model_reset();
    tx_q.delete();
    ovf_m = 1'b0;
    cyc_m = 32'd0;
  endfunction

  // One bus cycle: drive at the falling edge, predict, check at the next one
  task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic we, input logic rdy);
    logic [31:0] exp_q;
    logic        q_known;
    logic        mmio;
    logic [1:0]  off;
    int          idx;
    bus.address_dmem = addr;
    bus.data         = wdata;
    bus.wren         = we;
    bus.tx_ready     = rdy;
    mmio    = (addr[31:16] == 16'hFFFF);
    off     = addr[1:0];
    idx     = int'(addr[11:0]);
    q_known = 1'b1;
    if (mmio) begin
      case (off)
        2'd0:    exp_q = 32'd0;
        2'd1:    exp_q = status_word();
        2'd2:    exp_q = cyc_m;
        default: exp_q = 32'h0350_0001;
      endcase
    end else begin
      exp_q   = ram_m[idx];
      q_known = ram_known[idx];
    end
    if (tx_q.size() > 0 && rdy) void'(tx_q.pop_front());
    if (mmio && we && off == 2'd0) begin
      if (tx_q.size() < 8) tx_q.push_back(wdata[7:0]);
      else                 ovf_m = 1'b1;
    end
    if (mmio && we && off == 2'd1) ovf_m = 1'b0;
    if (mmio && we && off == 2'd2) cyc_m = wdata;
    else                           cyc_m = cyc_m + 32'd1;
    if (!mmio && we) begin
      ram_m[idx]     = wdata;
      ram_known[idx] = 1'b1;
    end
    @(posedge clock);
    @(negedge clock);
    last_q = bus.q_dmem;
    if (q_known) check_output("q_dmem", bus.q_dmem, exp_q);
    check_output("tx_valid", 32'(bus.tx_valid), 32'(tx_q.size() > 0));
    check_output("tx_data", 32'(bus.tx_data), (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'd0);
  endtask

  initial begin
    logic [7:0] got_bytes [$];
    logic       rdy;
    int         sel;
    int         idx;
    n_compared   = 0;
    n_mismatched = 0;
    reset            = 1'b1;
    bus.address_dmem = 32'd0;
    bus.data         = 32'd0;
    bus.wren         = 1'b0;
    bus.tx_ready     = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_output("reset_q", bus.q_dmem, 32'd0);
    check_output("reset_valid", 32'(bus.tx_valid), 32'd0);
    check_output("reset_txdata", 32'(bus.tx_data), 32'd0);
    reset = 1'b0;

    $display("[TB] cycle counter after reset");
    for (int k = 1; k <= 10; k++) begin
      apply_stimulus(mmio_addr(2'd2), 32'd0, 1'b0, 1'b0);
      if (k == 3)  check_output("cycle_edge3", last_q, 32'd2);
      if (k == 10) check_output("cycle_edge10", last_q, 32'd9);
    end

    $display("[TB] RAM write, read and alias");
    apply_stimulus(32'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    apply_stimulus(32'd5, 32'd0, 1'b0, 1'b0);
    check_output("ram_rd5", last_q, 32'hDEADBEEF);
    apply_stimulus(32'd5 + 32'd4096, 32'd0, 1'b0, 1'b0);
    check_output("ram_alias", last_q, 32'hDEADBEEF);
    for (int i = 16; i < 48; i++) apply_stimulus(ram_addr(i), $urandom, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(16, 47);
      apply_stimulus(ram_addr(idx), $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] cycle counter load and wrap");
    apply_stimulus(mmio_addr(2'd2), 32'hFFFF_FFFE, 1'b1, 1'b0);
    apply_stimulus(mmio_addr(2'd2), 32'd0, 1'b0, 1'b0);
    check_output("cycle_load", last_q, 32'hFFFF_FFFE);
    apply_stimulus(mmio_addr(2'd2), 32'd0, 1'b0, 1'b0);
    apply_stimulus(mmio_addr(2'd2), 32'd0, 1'b0, 1'b0);
    check_output("cycle_wrap", last_q, 32'd0);

    $display("[TB] FIFO fill, overflow, push+pop at full");
    for (int b = 8'h41; b <= 8'h49; b++) apply_stimulus(mmio_addr(2'd0), 32'(b), 1'b1, 1'b0);
    apply_stimulus(mmio_addr(2'd1), 32'd0, 1'b0, 1'b0);
    check_output("status_full_ovf", last_q, 32'h0000_0128);
    apply_stimulus(mmio_addr(2'd0), 32'h0000_005A, 1'b1, 1'b1);
    apply_stimulus(mmio_addr(2'd1), 32'd0, 1'b0, 1'b0);
    check_output("status_push_pop_full", last_q, 32'h0000_0128);
    apply_stimulus(mmio_addr(2'd1), $urandom, 1'b1, 1'b0);
    apply_stimulus(mmio_addr(2'd1), 32'd0, 1'b0, 1'b0);
    check_output("status_ovf_clr", last_q, 32'h0000_0028);
    apply_stimulus(mmio_addr(2'd3), $urandom, 1'b1, 1'b0);
    apply_stimulus(mmio_addr(2'd3), 32'd0, 1'b0, 1'b0);
    check_output("id_value", last_q, 32'h0350_0001);

    $display("[TB] drain with alternating backpressure");
    for (int i = 0; i < 20; i++) begin
      rdy = 1'(i % 2);
      if (bus.tx_valid && rdy) got_bytes.push_back(bus.tx_data);
      apply_stimulus(mmio_addr(2'd3), 32'd0, 1'b0, rdy);
    end
    check_output("drain_len", 32'(got_bytes.size()), 32'd8);
    for (int j = 0; j < 8; j++) begin
      if (j < got_bytes.size()) check_output("drain_byte", 32'(got_bytes[j]), 32'(exp_drain[j]));
    end

    $display("[TB] randomized mixed traffic");
    for (int i = 0; i < 250; i++) begin
      sel = $urandom_range(0, 9);
      rdy = ($urandom_range(0, 3) == 0);
      case (sel)
        0, 1: apply_stimulus(ram_addr($urandom_range(16, 47)), $urandom, 1'b1, rdy);
        2:    apply_stimulus(ram_addr(5), 32'd0, 1'b0, rdy);
        3:    apply_stimulus(ram_addr($urandom_range(16, 47)), 32'd0, 1'b0, rdy);
        4, 5: apply_stimulus(mmio_addr(2'd0), $urandom, 1'b1, rdy);
        6:    apply_stimulus(mmio_addr(2'd1), 32'd0, 1'b0, rdy);
        7:    apply_stimulus(mmio_addr(2'd1), $urandom, 1'($urandom_range(0, 1)), rdy);
        8:    apply_stimulus(mmio_addr(2'd2), $urandom, 1'($urandom_range(0, 3) == 0), rdy);
        default: apply_stimulus(mmio_addr(2'($urandom)), 32'd0, 1'b0, rdy);
      endcase
    end

    $display("[TB] reset in the middle of a drain");
    for (int i = 0; i < 12; i++) apply_stimulus(mmio_addr(2'd3), 32'd0, 1'b0, 1'b1);
    for (int b = 8'h61; b < 8'h66; b++) apply_stimulus(mmio_addr(2'd0), 32'(b), 1'b1, 1'b0);
    check_output("pre_reset_valid", 32'(bus.tx_valid), 32'd1);
    bus.wren     = 1'b0;
    bus.tx_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_output("async_reset_valid", 32'(bus.tx_valid), 32'd0);
    check_output("async_reset_txdata", 32'(bus.tx_data), 32'd0);
    check_output("async_reset_q", bus.q_dmem, 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    apply_stimulus(mmio_addr(2'd1), 32'd0, 1'b0, 1'b0);
    check_output("status_after_reset", last_q, 32'h0000_0010);
    apply_stimulus(ram_addr(5), 32'd0, 1'b0, 1'b0);
    check_output("ram_kept", last_q, 32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
